bit64_seq_subtractor: RTL

- Multi-cycle WIDTH-bit subtractor: d = a - b, computed as a + ~b + 1 through one SLICE-bit ripple-borrow slice, reused once per cycle.
- Counterpart to the 64-bit ripple-carry adder; datapath-side unit for the ALU experiments.
- Valid/ready on input and output; one operation in flight at a time.

---
 rtl/bit64_seq_subtractor.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bit64_seq_subtractor.sv
// Multi-cycle WIDTH-bit subtractor d = a + ~b + 1, one SLICE-bit ripple slice per cycle.
// Define SUB_FLAGS_EN to add the registered zero/ovf result flags.
module bit64_seq_subtractor #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
`ifdef SUB_FLAGS_EN
    output logic             zero,
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int unsigned NS   = WIDTH / SLICE;
    localparam int unsigned CW   = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] nb_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] d_nx;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic [SLICE-1:0] ssum;
    logic [SLICE:0]   chain;
    logic             scout;
    logic             last_slice;

    assign last_slice = (state == RUN) && (cnt == LAST);

    // One SLICE-bit ripple-carry slice; b is already stored inverted.
    always_comb begin
        sa       = a_r[cnt*SLICE +: SLICE];
        sb       = nb_r[cnt*SLICE +: SLICE];
        ssum     = '0;
        chain    = '0;
        chain[0] = carry;
        for (int unsigned i = 0; i < SLICE; i++) begin
            ssum[i]    = sa[i] ^ sb[i] ^ chain[i];
            chain[i+1] = (sa[i] & sb[i]) | (chain[i] & (sa[i] ^ sb[i]));
        end
        scout = chain[SLICE];
    end

    always_comb begin
        d_nx                     = d_r;
        d_nx[cnt*SLICE +: SLICE] = ssum;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_r       <= '0;
            nb_r      <= '0;
            d_r       <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            borrow    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        nb_r  <= ~b;
                        carry <= 1'b1;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    d_r   <= d_nx;
                    carry <= scout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        borrow    <= ~scout;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign d = d_r;

`ifdef SUB_FLAGS_EN
    // Signed overflow: operand signs differ (nb_r holds ~b) and result sign differs from a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (last_slice) begin
            zero <= (d_nx == '0);
            ovf  <= (a_r[WIDTH-1] == nb_r[WIDTH-1]) && (ssum[SLICE-1] != a_r[WIDTH-1]);
        end
    end
`endif

endmodule
